// File: rtl/csr_apb_master_pkg.sv
// csr_apb_master_pkg: shared APB requester state encoding and protection default
package csr_apb_master_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_t;
  localparam logic [1:0] CSR_PROT_DEFAULT = 2'b00;
endpackage

// File: rtl/csr_apb_master.sv
// csr_apb_master: turns a valid/ready command stream into APB SETUP/ACCESS transfers with timeout
module csr_apb_master
  import csr_apb_master_pkg::*;
#(
  parameter int CSR_ADDR_WIDTH = 8,
  parameter int CSR_DATA_WIDTH = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                        pclk,
  input  logic                        preset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [CSR_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic                        cmd_write,
  input  logic [CSR_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [CSR_DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [1:0]                  cmd_prot,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [CSR_DATA_WIDTH-1:0]   rsp_rdata,
  output logic                        rsp_slverr,
  output logic                        rsp_timeout,
  output logic                        psel,
  output logic                        penable,
  output logic                        pwrite,
  output logic [CSR_ADDR_WIDTH-1:0]   paddr,
  output logic [1:0]                  pprot,
  output logic [CSR_DATA_WIDTH-1:0]   pwdata,
  output logic [CSR_DATA_WIDTH/8-1:0] pstrb,
  input  logic [CSR_DATA_WIDTH-1:0]   prdata,
  input  logic                        pready,
  input  logic                        pslverr
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX = '1;
  apb_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic timeout_hit;
  assign cmd_ready = state == IDLE;
  // pready has priority: an abort only happens on a cycle the slave is still stalling
  assign timeout_hit = (TIMEOUT != 0) && cnt == CNT_LAST && !pready;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      IDLE: state_n = cmd_valid ? SETUP : IDLE;
      SETUP: begin
        state_n = ACCESS;
        cnt_n = '0;
      end
      ACCESS: begin
        state_n = (pready || timeout_hit) ? RESP : ACCESS;
        cnt_n = (pready || cnt == CNT_MAX) ? cnt : cnt + CW'(1);
      end
      RESP: state_n = rsp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state <= IDLE;
      cnt <= '0;
      psel <= 1'b0;
      penable <= 1'b0;
      pwrite <= 1'b0;
      paddr <= '0;
      pprot <= CSR_PROT_DEFAULT;
      pwdata <= '0;
      pstrb <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_slverr <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      psel <= state_n == SETUP || state_n == ACCESS;
      penable <= state_n == ACCESS;
      rsp_valid <= state_n == RESP;
      if (state == IDLE && cmd_valid) begin
        paddr <= cmd_addr;
        pprot <= cmd_prot;
        pwrite <= cmd_write;
        pwdata <= cmd_write ? cmd_wdata : '0;
        pstrb <= cmd_write ? cmd_strb : '0;
      end
      if (state == ACCESS && state_n == RESP) begin
        rsp_rdata <= (pready && !pwrite) ? prdata : '0;
        rsp_slverr <= pready ? pslverr : 1'b1;
        rsp_timeout <= !pready;
      end
    end
  end
endmodule

// File: tb/tb_csr_apb_master.sv
// tb_csr_apb_master: directed table, random transfers against a transfer-level model, reset corner case
module tb_csr_apb_master;
  localparam int TO = 16;
  typedef struct {
    logic [7:0]  addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  prot;
    int          waits;
    logic [31:0] srdata;
    logic        sslverr;
    int          hold;
    logic [31:0] e_rdata;
    logic        e_slverr;
    logic        e_to;
    int          e_acc;
  } vec_t;
  logic pclk = 0, preset = 1;
  logic cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [7:0] cmd_addr = 0;
  logic [31:0] cmd_wdata = 0;
  logic [3:0] cmd_strb = 0;
  logic [1:0] cmd_prot = 0;
  logic rsp_valid, rsp_ready = 0, rsp_slverr, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic psel, penable, pwrite;
  logic [7:0] paddr;
  logic [1:0] pprot;
  logic [31:0] pwdata, prdata = 0;
  logic [3:0] pstrb;
  logic pready = 0, pslverr = 0;
  int n_cmp = 0, n_bad = 0;
  vec_t vecs[8];
  csr_apb_master #(.CSR_ADDR_WIDTH(8), .CSR_DATA_WIDTH(32), .TIMEOUT(TO)) dut (
    .pclk(pclk), .preset(preset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .cmd_prot(cmd_prot), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pprot(pprot), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );
  always #5 pclk = ~pclk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(logic [7:0] a, logic w, logic [31:0] wd, logic [3:0] s, logic [1:0] p,
                              int wt, logic [31:0] sr, logic se, int h, logic [31:0] er, logic ee,
                              logic et, int ea);
    vec_t v;
    v.addr = a; v.write = w; v.wdata = wd; v.strb = s; v.prot = p; v.waits = wt;
    v.srdata = sr; v.sslverr = se; v.hold = h;
    v.e_rdata = er; v.e_slverr = ee; v.e_to = et; v.e_acc = ea;
    return v;
  endfunction
  // transfer-level model: a slave that stalls TO cycles or more is aborted after TO ACCESS cycles
  function automatic vec_t model(vec_t v);
    vec_t r = v;
    logic t = TO != 0 && v.waits >= TO;
    r.e_to = t;
    r.e_acc = t ? TO : v.waits + 1;
    r.e_rdata = (t || v.write) ? 32'h0 : v.srdata;
    r.e_slverr = t | v.sslverr;
    return r;
  endfunction
  // entered and left at a negedge with the DUT idle; acts as both requester and slave
  task automatic run_xfer(input vec_t v);
    int acc = 0, setup = 0, edges = 0, bad_ctrl = 0, bad_rdy = 0, bad_hold = 0;
    logic got = 0;
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1; cmd_addr = v.addr; cmd_write = v.write; cmd_wdata = v.wdata;
    cmd_strb = v.strb; cmd_prot = v.prot;
    pready = 1'($urandom); prdata = $urandom; pslverr = 1'($urandom);
    rsp_ready = 1'($urandom);
    while (!got && edges < 100) begin
      @(posedge pclk); edges++;
      @(negedge pclk);
      cmd_valid = 0; cmd_addr = 8'($urandom); cmd_write = 1'($urandom);
      cmd_wdata = $urandom; cmd_strb = 4'($urandom); cmd_prot = 2'($urandom);
      if (rsp_valid) got = 1;
      else begin
        if (psel && !penable) setup++;
        if (psel && penable) acc++;
        if (!psel || cmd_ready) bad_rdy++;
        if (paddr !== v.addr || pwrite !== v.write || pprot !== v.prot ||
            pwdata !== (v.write ? v.wdata : 32'h0) || pstrb !== (v.write ? v.strb : 4'h0)) bad_ctrl++;
        if (psel && penable) begin
          pready = acc > v.waits;
          prdata = pready ? v.srdata : $urandom;
          pslverr = pready ? v.sslverr : 1'($urandom);
        end else begin
          pready = 1'($urandom); prdata = $urandom; pslverr = 1'($urandom);
        end
        rsp_ready = 1'($urandom);
      end
    end
    chk("rsp_seen", got, 1);
    if (!got) return;
    chk("setup_cycles", setup, 1);
    chk("access_cycles", acc, v.e_acc);
    chk("latency", edges, v.e_acc + 2);
    chk("bus_released", {psel, penable}, 0);
    chk("ctrl_stable", bad_ctrl, 0);
    chk("busy_no_ready", bad_rdy, 0);
    chk("rsp_rdata", rsp_rdata, v.e_rdata);
    chk("rsp_slverr", rsp_slverr, v.e_slverr);
    chk("rsp_timeout", rsp_timeout, v.e_to);
    for (int i = 0; i < v.hold; i++) begin
      rsp_ready = 0; cmd_valid = 1'($urandom); pready = 1'($urandom); pslverr = 1'($urandom);
      @(posedge pclk); edges++;
      @(negedge pclk);
      if (!rsp_valid || rsp_rdata !== v.e_rdata || rsp_slverr !== v.e_slverr ||
          rsp_timeout !== v.e_to || cmd_ready || psel) bad_hold++;
    end
    chk("rsp_hold", bad_hold, 0);
    rsp_ready = 1;
    @(posedge pclk); edges++;
    @(negedge pclk);
    cmd_valid = 0; rsp_ready = 0;
    chk("rsp_drop", rsp_valid, 0);
    chk("xfer_cycles", edges, v.e_acc + v.hold + 3);
  endtask
  initial begin
    vec_t v;
    vecs[0] = mk(8'h04, 1, 32'hDEADBEEF, 4'hF, 2'd0, 1, 32'hAAAA5555, 0, 0, 32'h0, 0, 0, 2);
    vecs[1] = mk(8'h08, 0, 32'h11111111, 4'hF, 2'd1, 0, 32'h12345678, 0, 0, 32'h12345678, 0, 0, 1);
    vecs[2] = mk(8'h10, 1, 32'h00000001, 4'h3, 2'd2, 0, 32'h99999999, 1, 0, 32'h0, 1, 0, 1);
    vecs[3] = mk(8'h20, 0, 32'h0, 4'h0, 2'd0, 255, 32'h77777777, 0, 0, 32'h0, 1, 1, 16);
    vecs[4] = mk(8'h0C, 0, 32'h0, 4'h0, 2'd3, 0, 32'hCAFEF00D, 0, 5, 32'hCAFEF00D, 0, 0, 1);
    vecs[5] = mk(8'h30, 0, 32'h0, 4'h0, 2'd0, 15, 32'h0BADC0DE, 0, 1, 32'h0BADC0DE, 0, 0, 16);
    vecs[6] = mk(8'hFF, 1, 32'h5A5A5A5A, 4'h8, 2'd1, 16, 32'h0, 0, 2, 32'h0, 1, 1, 16);
    vecs[7] = mk(8'h44, 0, 32'h0, 4'h0, 2'd2, 3, 32'h00000055, 1, 0, 32'h00000055, 1, 0, 4);
    #12;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_bus", {psel, penable, pwrite, pprot}, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", {pwdata, pstrb}, 0);
    chk("rst_rsp", {rsp_valid, rsp_slverr, rsp_timeout}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    @(negedge pclk);
    preset = 0;
    @(negedge pclk);
    foreach (vecs[i]) run_xfer(vecs[i]);
    for (int i = 0; i < 40; i++) begin
      v.addr = 8'($urandom); v.write = 1'($urandom); v.wdata = $urandom; v.strb = 4'($urandom);
      v.prot = 2'($urandom); v.waits = $urandom_range(0, 20); v.srdata = $urandom;
      v.sslverr = 1'($urandom); v.hold = $urandom_range(0, 3);
      run_xfer(model(v));
    end
    cmd_valid = 1; cmd_addr = 8'h5C; cmd_write = 0; pready = 0;
    @(posedge pclk);
    @(negedge pclk);
    cmd_valid = 0;
    repeat (3) @(negedge pclk);
    chk("pre_rst_access", {psel, penable}, 2'b11);
    #2 preset = 1;
    #1;
    chk("async_rst_bus", {psel, penable}, 0);
    chk("async_rst_rsp", rsp_valid, 0);
    chk("async_rst_ready", cmd_ready, 1);
    chk("async_rst_paddr", paddr, 0);
    @(negedge pclk);
    preset = 0;
    @(negedge pclk);
    chk("post_rst_idle", {rsp_valid, psel}, 0);
    run_xfer(mk(8'h18, 0, 32'h0, 4'h0, 2'd0, 2, 32'hFEEDFACE, 0, 0, 32'hFEEDFACE, 0, 0, 3));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
